// File: rtl/clkgate_idle_ctrl.sv
// Per-channel automatic clock gating with idle hysteresis, force overrides and a clock-running flag.
// Latency: wake sets en one edge after busy/force_on; no flow control, purely level-driven.
module clkgate_idle_ctrl #(
    parameter int              N_CH          = 4,
    parameter int              HYST_W        = 4,
    parameter logic [N_CH-1:0] RESET_ENABLED = {N_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   busy,
    input  logic [N_CH-1:0]   force_on,
    input  logic [N_CH-1:0]   force_off,
    input  logic [HYST_W-1:0] hyst,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   gated,
    output logic [N_CH-1:0]   ready
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [HYST_W-1:0] ctr_q, ctr_d;
        logic              en_q, en_d;
        logic              ready_q, ready_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RESET_ENABLED[i] ? ST_RUN : ST_OFF;
                en_q    <= RESET_ENABLED[i];
                ctr_q   <= '0;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                en_q    <= en_d;
                ctr_q   <= ctr_d;
                ready_q <= ready_d;
            end
        end

        // Priority within every state: force_on > force_off > busy > idle countdown.
        always_comb begin
            state_d = state_q;
            ctr_d   = ctr_q;
            case (state_q)
                ST_RUN: begin
                    if (force_on[i]) begin
                        state_d = ST_RUN;
                    end else if (force_off[i]) begin
                        state_d = ST_OFF;
                    end else if (busy[i]) begin
                        state_d = ST_RUN;
                    end else if (hyst == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_COUNT;
                        ctr_d   = hyst;
                    end
                end
                ST_COUNT: begin
                    if (force_on[i]) begin
                        state_d = ST_RUN;
                    end else if (force_off[i]) begin
                        state_d = ST_OFF;
                    end else if (busy[i]) begin
                        state_d = ST_RUN;
                    end else if (ctr_q <= HYST_W'(1)) begin
                        state_d = ST_OFF;
                    end else begin
                        ctr_d = ctr_q - HYST_W'(1);
                    end
                end
                ST_OFF: begin
                    if (force_on[i]) begin
                        state_d = ST_RUN;
                    end else if (force_off[i]) begin
                        state_d = ST_OFF;
                    end else if (busy[i]) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_OFF;
            endcase
            en_d    = (state_d != ST_OFF);
            // en_q high now means the current edge already reached clk_out.
            ready_d = en_d & (ready_q | en_q);
        end

        assign gated[i] = ~en_q;
        assign ready[i] = ready_q;

`ifdef NOCLOCKGATES
        assign clk_out[i] = clk;
`else
        // Low-transparent latch: enable can only change while clk is low, so no runt pulses.
        logic en_lat;
        always_latch begin
            if (!clk) en_lat = en_q;
        end
        assign clk_out[i] = clk & en_lat;
`endif
    end

endmodule

// File: tb/tb_clkgate_idle_ctrl.sv
// Directed bench for clkgate_idle_ctrl: reset, idle hysteresis, wake, overrides, toggling and mid-count reset.
// Latency/backpressure: inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_clkgate_idle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] busy, force_on, force_off, hyst;
    wire  [3:0] clk_out, gated, ready;

    int errs = 0;
    int checks = 0;
    int ecnt[4] = '{0, 0, 0, 0};
    int base[4] = '{0, 0, 0, 0};
    int glitch = 0;
    logic [3:0] prev_co = 4'b0000;

    clkgate_idle_ctrl #(
        .N_CH(4),
        .HYST_W(4),
        .RESET_ENABLED(4'b0101)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .busy(busy),
        .force_on(force_on),
        .force_off(force_off),
        .hyst(hyst),
        .clk_out(clk_out),
        .gated(gated),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // Count gated-clock rising edges; any rise while clk is low is a glitch.
    always @(clk_out) begin
        for (int g = 0; g < 4; g++) begin
            if (clk_out[g] === 1'b1 && prev_co[g] !== 1'b1) begin
                ecnt[g]++;
                if (clk !== 1'b1) glitch++;
            end
        end
        prev_co = clk_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int g = 0; g < 4; g++) base[g] = ecnt[g];
    endtask

    function automatic int n_edges(input int g);
        return ecnt[g] - base[g];
    endfunction

    initial begin
        busy = '0; force_on = '0; force_off = '0; hyst = 4'd3;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_gated", gated, 4'b1010);
        check("rst_ready", ready, 4'b0000);
        check("rst_clk_out", clk_out, 4'b0101);

        // Release: ch0/ch2 idle out after 3 more edges with hyst=3.
        @(negedge clk) rst_n = 1'b1;
        tick();
        snap();
        check("rel_ready", ready, 4'b0101);
        check("rel_gated", gated, 4'b1010);
        repeat (2) tick();
        check("rel_k2_gated", gated, 4'b1010);
        tick();
        check("rel_k3_gated", gated, 4'b1111);
        check("rel_k3_ready", ready, 4'b0000);
        repeat (2) tick();
        check("rel_edges0", n_edges(0), 3);
        check("rel_edges2", n_edges(2), 3);
        check("rel_edges1", n_edges(1), 0);
        check("rel_edges3", n_edges(3), 0);

        // One-cycle busy pulse on ch0 in OFF, hyst=2.
        hyst = 4'd2;
        busy[0] = 1'b1;
        tick();
        busy[0] = 1'b0;
        snap();
        check("wake_gated", gated[0], 1'b0);
        check("wake_ready", ready[0], 1'b0);
        tick();
        check("wake_k1_ready", ready[0], 1'b1);
        check("wake_k1_edges", n_edges(0), 1);
        tick();
        check("wake_k2_gated", gated[0], 1'b0);
        tick();
        check("wake_k3_gated", gated[0], 1'b1);
        check("wake_k3_ready", ready[0], 1'b0);
        check("wake_k3_edges", n_edges(0), 3);

        // ch1: busy returns mid-count, then a fresh full count; hyst change mid-count ignored.
        hyst = 4'd3;
        busy[1] = 1'b1;
        tick();
        busy[1] = 1'b0;
        snap();
        tick();
        check("cnt_a1_ready", ready[1], 1'b1);
        tick();
        busy[1] = 1'b1;
        tick();
        check("cnt_a3_gated", gated[1], 1'b0);
        busy[1] = 1'b0;
        tick();
        hyst = 4'd9;
        repeat (2) tick();
        check("cnt_a6_gated", gated[1], 1'b0);
        check("cnt_a6_ready", ready[1], 1'b1);
        tick();
        check("cnt_a7_gated", gated[1], 1'b1);
        check("cnt_a7_ready", ready[1], 1'b0);
        check("cnt_a7_edges", n_edges(1), 7);
        hyst = 4'd3;

        // ch2: force_on and force_off together, then release force_on.
        force_on[2] = 1'b1;
        force_off[2] = 1'b1;
        tick();
        snap();
        check("frc_gated", gated[2], 1'b0);
        repeat (6) tick();
        check("frc_hold_gated", gated[2], 1'b0);
        check("frc_hold_ready", ready[2], 1'b1);
        check("frc_hold_edges", n_edges(2), 6);
        force_on[2] = 1'b0;
        tick();
        check("frc_off_gated", gated[2], 1'b1);
        check("frc_off_ready", ready[2], 1'b0);
        check("frc_off_edges", n_edges(2), 7);
        force_off[2] = 1'b0;

        // ch3: hyst=0 with busy toggling every cycle.
        hyst = 4'd0;
        snap();
        for (int i = 0; i < 4; i++) begin
            busy[3] = (i % 2 == 0);
            tick();
            check("tog_gated", gated[3], (i % 2 == 0) ? 1'b0 : 1'b1);
            check("tog_ready", ready[3], 1'b0);
        end
        busy[3] = 1'b0;
        check("tog_edges", n_edges(3), 2);
        check("glitch_count", glitch, 0);

        // ch0 mid-count (ctr=5) hit by reset while clk is high.
        hyst = 4'd5;
        busy[0] = 1'b1;
        tick();
        busy[0] = 1'b0;
        tick();
        check("mid_ready_pre", ready[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 4'b0000);
        check("mid_rst_gated", gated, 4'b1010);
        check("mid_rst_clk_out", clk_out, 4'b0001);
        tick();
        check("mid_rst_clk_out2", clk_out, 4'b0101);
        check("mid_rst_ready2", ready, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        hyst = 4'd1;
        tick();
        check("mid_rel_ready", ready, 4'b0101);
        check("mid_rel_gated", gated, 4'b1010);
        tick();
        check("mid_rel_k1_gated", gated, 4'b1111);
        check("glitch_final", glitch, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
